run_detector: RTL and testbench

- Parametrised run-length detector for a serial bit stream `w`.
- Asserts `z` while the current run of identical bits (0s or 1s) has reached a runtime-programmable threshold.
- Also counts qualifying runs and emits a one-shot event per run.
- Supersedes the fixed 4-deep Moore detector; adds sample-valid gating, Moore/Mealy output mode, saturation and event statistics, for use in the NPC test/peripheral area.

---
 rtl/run_det_pkg.sv | 17 +
 rtl/run_det_sat_cnt.sv | 32 +++
 rtl/run_detector.sv | 107 ++++++++++
 tb/tb_run_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector.
package run_det_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Threshold of 0 means "every sample qualifies"; oversize thresholds clamp to the counter ceiling.
  function automatic int unsigned clamp_thr(input int unsigned thr, input int unsigned max_run);
    if (thr == 0) return 1;
    if (thr > max_run) return max_run;
    return thr;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max_val);
    return (value >= max_val) ? value : value + 1;
  endfunction

endpackage

// File: rtl/run_det_sat_cnt.sv
// Saturating up-counter with sync clear and load-to-one; clear wins over load, load over increment.
module run_det_sat_cnt
  import run_det_pkg::*;
#(
  parameter int          W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg, q_next;

  always_comb begin
    q_next = q_reg;
    if (clr)        q_next = '0;
    else if (load1) q_next = W'(1);
    else if (inc)   q_next = W'(sat_inc(32'(q_reg), MAX));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_reg <= '0;
    else      q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: flags runs of identical bits reaching a programmable threshold
// and emits one event per qualifying run.
module run_detector
  import run_det_pkg::*;
#(
  parameter int MAX_RUN = 15,
  parameter int CNT_W   = $clog2(MAX_RUN + 1),
  parameter int EVT_W   = 16,
  parameter bit MEALY   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             w,
  input  logic [CNT_W-1:0] thr,
  output logic             z,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic             evt_pulse,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam int unsigned EVT_MAX = (EVT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << EVT_W) - 32'd1);

  state_t           state_reg, state_next;
  logic             run_bit_reg, run_bit_next;
  logic             hit_reg, hit_next;
  logic             evt_pulse_reg;
  logic             accept, same, restart, fire;
  logic [CNT_W-1:0] thr_eff, next_len;

  assign accept   = in_valid && !clr;
  assign thr_eff  = CNT_W'(clamp_thr(32'(thr), MAX_RUN));
  assign same     = (state_reg == ST_RUN) && (w == run_bit_reg);
  assign restart  = !same;
  assign next_len = same ? CNT_W'(sat_inc(32'(run_len), MAX_RUN)) : CNT_W'(1);
  // A restarted run may fire even if the previous run already hit.
  assign fire     = accept && (next_len >= thr_eff) && (restart || !hit_reg);

  always_comb begin
    state_next   = state_reg;
    run_bit_next = run_bit_reg;
    hit_next     = hit_reg;
    if (clr) begin
      state_next   = ST_IDLE;
      run_bit_next = 1'b0;
      hit_next     = 1'b0;
    end else if (accept) begin
      case (state_reg)
        ST_IDLE: begin
          state_next   = ST_RUN;
          run_bit_next = w;
        end
        ST_RUN: begin
          if (restart) run_bit_next = w;
        end
        default: state_next = ST_IDLE;
      endcase
      hit_next = fire || (same && hit_reg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      run_bit_reg   <= 1'b0;
      hit_reg       <= 1'b0;
      evt_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      run_bit_reg   <= run_bit_next;
      hit_reg       <= hit_next;
      evt_pulse_reg <= fire;
    end
  end

  run_det_sat_cnt #(.W(CNT_W), .MAX(MAX_RUN)) u_run_len (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load1 (accept && restart),
    .inc   (accept && same),
    .q     (run_len)
  );

  run_det_sat_cnt #(.W(EVT_W), .MAX(EVT_MAX)) u_evt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .load1 (1'b0),
    .inc   (fire),
    .q     (evt_cnt)
  );

  generate
    if (MEALY) begin : g_mealy
      assign z = accept && (next_len >= thr_eff);
    end else begin : g_moore
      assign z = (state_reg == ST_RUN) && (run_len >= thr_eff);
    end
  endgenerate

  assign run_bit   = run_bit_reg;
  assign evt_pulse = evt_pulse_reg;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench: Moore, Mealy and narrow-event-counter instances share one stimulus stream.
module tb_run_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic       w;
  logic [3:0] thr;

  logic        z_m, run_bit_m, evt_pulse_m;
  logic [3:0]  run_len_m;
  logic [15:0] evt_cnt_m;
  logic        z_e, run_bit_e, evt_pulse_e;
  logic [3:0]  run_len_e;
  logic [15:0] evt_cnt_e;
  logic        z_s, run_bit_s, evt_pulse_s;
  logic [3:0]  run_len_s;
  logic [1:0]  evt_cnt_s;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  run_detector #(.MAX_RUN(15), .EVT_W(16), .MEALY(1'b0)) dut_moore (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .w(w), .thr(thr),
    .z(z_m), .run_bit(run_bit_m), .run_len(run_len_m), .evt_pulse(evt_pulse_m), .evt_cnt(evt_cnt_m)
  );

  run_detector #(.MAX_RUN(15), .EVT_W(16), .MEALY(1'b1)) dut_mealy (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .w(w), .thr(thr),
    .z(z_e), .run_bit(run_bit_e), .run_len(run_len_e), .evt_pulse(evt_pulse_e), .evt_cnt(evt_cnt_e)
  );

  run_detector #(.MAX_RUN(15), .EVT_W(2), .MEALY(1'b0)) dut_small (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .w(w), .thr(thr),
    .z(z_s), .run_bit(run_bit_s), .run_len(run_len_s), .evt_pulse(evt_pulse_s), .evt_cnt(evt_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("assertion on %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic b);
    in_valid = v;
    w        = b;
  endtask

  task automatic do_clr();
    clr = 1'b1; put(1'b0, 1'b0); tick();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; w = 1'b0; thr = 4'd4;
    tick(); tick();
    chk("rst_z_m", z_m, 0);
    chk("rst_z_e", z_e, 0);
    chk("rst_run_len", run_len_m, 0);
    chk("rst_run_bit", run_bit_m, 0);
    chk("rst_evt_pulse", evt_pulse_m, 0);
    chk("rst_evt_cnt", evt_cnt_m, 0);
    rst = 1'b1;
    tick();

    // Five zeros, thr=4
    for (int i = 1; i <= 5; i++) begin
      put(1'b1, 1'b0); #1;
      if (i == 3) chk("t1_mealy_z_s3", z_e, 0);
      if (i == 4) chk("t1_mealy_z_s4", z_e, 1);
      tick();
      if (i == 3) chk("t1_z_after3", z_m, 0);
      if (i == 4) begin
        chk("t1_z_after4", z_m, 1);
        chk("t1_pulse_after4", evt_pulse_m, 1);
      end
    end
    put(1'b0, 1'b0);
    chk("t1_run_len", run_len_m, 5);
    chk("t1_pulse_gone", evt_pulse_m, 0);
    chk("t1_evt_cnt", evt_cnt_m, 1);

    // 1,1,1,0,1,1,1,1
    do_clr();
    chk("t2_clr_run_len", run_len_m, 0);
    chk("t2_clr_evt_cnt", evt_cnt_m, 0);
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, (i == 4) ? 1'b0 : 1'b1);
      tick();
      if (i == 3) begin
        chk("t2_z_after3", z_m, 0);
        chk("t2_len_after3", run_len_m, 3);
      end
      if (i == 4) begin
        chk("t2_len_after0", run_len_m, 1);
        chk("t2_bit_after0", run_bit_m, 0);
      end
      if (i == 7) chk("t2_z_after7", z_m, 0);
    end
    put(1'b0, 1'b0);
    chk("t2_z_after8", z_m, 1);
    chk("t2_evt_cnt", evt_cnt_m, 1);
    chk("t2_run_bit", run_bit_m, 1);

    // Mealy with thr=3
    do_clr();
    thr = 4'd3;
    for (int i = 1; i <= 3; i++) begin
      put(1'b1, 1'b1); #1;
      if (i == 2) chk("t3_mealy_z_s2", z_e, 0);
      if (i == 3) chk("t3_mealy_z_s3", z_e, 1);
      tick();
    end
    put(1'b0, 1'b1); #1;
    chk("t3_mealy_idle_z", z_e, 0);
    chk("t3_moore_idle_z", z_m, 1);

    // Saturation with thr=15
    do_clr();
    thr = 4'd15;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      put(1'b1, 1'b0); tick();
      pulses += int'(evt_pulse_m);
    end
    put(1'b0, 1'b0); tick();
    pulses += int'(evt_pulse_m);
    chk("t4_pulses", pulses, 1);
    chk("t4_run_len_sat", run_len_m, 15);
    chk("t4_z_held", z_m, 1);
    chk("t4_evt_cnt", evt_cnt_m, 1);

    // Lower thr mid-run
    do_clr();
    thr = 4'd8;
    for (int i = 1; i <= 6; i++) begin
      put(1'b1, 1'b1); tick();
    end
    put(1'b0, 1'b1);
    chk("t5_z_thr8", z_m, 0);
    chk("t5_cnt_thr8", evt_cnt_m, 0);
    thr = 4'd2; #1;
    chk("t5_z_thr2_now", z_m, 1);
    chk("t5_no_pulse_yet", evt_pulse_m, 0);
    tick();
    chk("t5_no_pulse_idle", evt_pulse_m, 0);
    put(1'b1, 1'b1); tick();
    chk("t5_pulse_lowered", evt_pulse_m, 1);
    chk("t5_cnt_lowered", evt_cnt_m, 1);
    tick();
    chk("t5_single_event", evt_pulse_m, 0);
    chk("t5_cnt_hold", evt_cnt_m, 1);

    // thr=0 acts as 1: every alternating sample is an event; 2-bit counter saturates
    do_clr();
    thr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, i[0]); tick();
      chk("t5_thr0_pulse", evt_pulse_m, 1);
    end
    put(1'b0, 1'b0);
    chk("t5_thr0_cnt", evt_cnt_m, 5);
    chk("t5_small_sat", evt_cnt_s, 3);
    chk("t5_thr0_len", run_len_m, 1);

    // clr together with in_valid
    do_clr();
    thr = 4'd4;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 1'b1); tick();
    end
    clr = 1'b1; put(1'b1, 1'b1); #1;
    chk("t6_mealy_z_clr", z_e, 0);
    tick();
    clr = 1'b0; put(1'b0, 1'b0);
    chk("t6_clr_len", run_len_m, 0);
    chk("t6_clr_cnt", evt_cnt_m, 0);
    chk("t6_clr_z", z_m, 0);

    // Async reset mid-run
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 1'b1); tick();
    end
    chk("t6_pre_rst_cnt", evt_cnt_m, 1);
    chk("t6_pre_rst_len", run_len_m, 5);
    rst = 1'b0; #1;
    chk("t6_rst_len", run_len_m, 0);
    chk("t6_rst_z", z_m, 0);
    chk("t6_rst_cnt", evt_cnt_m, 0);
    chk("t6_rst_bit", run_bit_m, 0);
    #2 rst = 1'b1;
    tick();
    chk("t6_fresh_len", run_len_m, 1);
    chk("t6_fresh_bit", run_bit_m, 1);
    chk("t6_fresh_pulse", evt_pulse_m, 0);
    put(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
